// File: rtl/mfm_pkg.sv
// Shared MFM definitions: encoder state, sync/gap constants and the
// byte-to-cell encoding function used by the serializer.
package mfm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mfm_state_e;

  // A1 with the clock cell of bit 2 removed.
  localparam logic [15:0] MFM_SYNC_A1   = 16'h4489;
  localparam logic [7:0]  MFM_SYNC_BYTE = 8'hA1;
  localparam logic [7:0]  MFM_GAP_BYTE  = 8'h4E;
  localparam logic [7:0]  MFM_ZERO_BYTE = 8'h00;

  // Encode one byte, MSB first, into 16 cells {clock, data} per bit.
  // A clock cell is written only between two zero data bits.
  function automatic logic [15:0] mfm_encode(input logic [7:0] data, input logic prev);
    logic [15:0] cells;
    logic        p;
    cells = 16'h0000;
    p     = prev;
    for (int i = 7; i >= 0; i--) begin
      cells = {cells[13:0], (~p & ~data[i]), data[i]};
      p     = data[i];
    end
    return cells;
  endfunction

endpackage

// File: rtl/mfm_encoder_if.sv
// Byte handshake between the track buffer (master) and the MFM encoder (slave).
interface mfm_encoder_if;

  logic [7:0] byte_in;
  logic       byte_mark;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_mark,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_mark,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/index_sync.sv
// Two-flop synchronizer for an active-low asynchronous strobe plus a
// registered one-cycle pulse on its synchronized falling edge. The pulse
// appears three clocks after the input falls. Shared with the data output stage.
module index_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_l,
  output logic fall_pulse
);

  logic meta_r;
  logic sync_r;
  logic sync_d_r;
  logic pulse_r;

  // Synchronize the strobe (idle high) and register its falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r   <= 1'b1;
      sync_r   <= 1'b1;
      sync_d_r <= 1'b1;
      pulse_r  <= 1'b0;
    end else begin
      meta_r   <= async_l;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
      pulse_r  <= sync_d_r & ~sync_r;
    end
  end

  assign fall_pulse = pulse_r;

endmodule

// File: rtl/mfm_encoder.sv
// MFM serializer: takes track bytes over a valid/ready handshake and emits
// back-to-back MFM cells, each held BIT_CLKS cycles. A1 with byte_mark
// becomes the 4489 sync pattern; an empty byte slot is filled and flagged.
// Build option MFM_ENC_GAP_FILL_EN: fill with the 4E gap byte instead of 00.
module mfm_encoder
  import mfm_pkg::*;
#(
  parameter int BIT_CLKS = 1
) (
  input  logic         clk5,
  input  logic         reset,
  input  logic         index_l,
  mfm_encoder_if.slave byte_if,
  output logic         mfm_out,
  output logic         cell_strobe,
  output logic         track_start,
  output logic         underrun
);

  localparam int             CW        = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0]  CLK_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0]  CLK_ZERO  = CW'(0);
  localparam logic [CW-1:0]  CLK_ONE   = CW'(1);
  localparam logic [3:0]     CELL_LAST = 4'd15;
  localparam logic [0:0]     S_IDLE    = ST_IDLE;
  localparam logic [0:0]     S_RUN     = ST_RUN;
`ifdef MFM_ENC_GAP_FILL_EN
  localparam logic [7:0]     FILL_BYTE = MFM_GAP_BYTE;
`else
  localparam logic [7:0]     FILL_BYTE = MFM_ZERO_BYTE;
`endif

  logic [0:0]    state_r,    state_nx;
  logic [3:0]    cell_cnt_r, cell_cnt_nx;
  logic [CW-1:0] clk_cnt_r,  clk_cnt_nx;
  logic [15:0]   shreg_r,    shreg_nx;
  logic          prev_r,     prev_nx;
  logic          mfm_r,      mfm_nx;
  logic          strobe_r,   strobe_nx;
  logic          ready_r,    ready_nx;
  logic          underrun_r;

  logic          handshake_s;
  logic          is_mark_s;
  logic [15:0]   load_cells_s;
  logic          load_prev_s;
  logic          set_underrun_s;
  logic          track_start_s;

  index_sync u_index_sync (
    .clk        (clk5),
    .rst        (reset),
    .async_l    (index_l),
    .fall_pulse (track_start_s)
  );

  // Pick what loads at the next byte slot: a handshaked byte, a sync mark, or fill.
  always_comb begin
    handshake_s  = byte_if.byte_valid & ready_r;
    is_mark_s    = byte_if.byte_mark & (byte_if.byte_in == MFM_SYNC_BYTE);
    load_cells_s = 16'h0000;
    load_prev_s  = 1'b0;
    if (handshake_s) begin
      if (is_mark_s) begin
        load_cells_s = MFM_SYNC_A1;
        load_prev_s  = 1'b1;
      end else begin
        load_cells_s = mfm_encode(byte_if.byte_in, prev_r);
        load_prev_s  = byte_if.byte_in[0];
      end
    end else begin
      load_cells_s = mfm_encode(FILL_BYTE, prev_r);
      load_prev_s  = FILL_BYTE[0];
    end
  end

  // Next-state logic for the cell/byte counters, shift register and outputs.
  always_comb begin
    state_nx       = state_r;
    cell_cnt_nx    = cell_cnt_r;
    clk_cnt_nx     = clk_cnt_r;
    shreg_nx       = shreg_r;
    prev_nx        = prev_r;
    mfm_nx         = mfm_r;
    strobe_nx      = 1'b0;
    set_underrun_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (handshake_s) begin
          state_nx    = S_RUN;
          mfm_nx      = load_cells_s[15];
          shreg_nx    = {load_cells_s[14:0], 1'b0};
          prev_nx     = load_prev_s;
          cell_cnt_nx = 4'd0;
          clk_cnt_nx  = CLK_ZERO;
          strobe_nx   = 1'b1;
        end else begin
          mfm_nx      = 1'b0;
        end
      end
      S_RUN: begin
        if (clk_cnt_r == CLK_LAST) begin
          clk_cnt_nx = CLK_ZERO;
          strobe_nx  = 1'b1;
          if (cell_cnt_r == CELL_LAST) begin
            // Byte boundary: the next byte (or fill) starts without a gap.
            mfm_nx         = load_cells_s[15];
            shreg_nx       = {load_cells_s[14:0], 1'b0};
            prev_nx        = load_prev_s;
            cell_cnt_nx    = 4'd0;
            set_underrun_s = ~handshake_s;
          end else begin
            mfm_nx      = shreg_r[15];
            shreg_nx    = {shreg_r[14:0], 1'b0};
            cell_cnt_nx = cell_cnt_r + 4'd1;
          end
        end else begin
          clk_cnt_nx = clk_cnt_r + CLK_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        mfm_nx   = 1'b0;
      end
    endcase
    // Ready is registered, so it is predicted for the cycle being entered.
    ready_nx = (state_nx == S_IDLE) |
               ((cell_cnt_nx == CELL_LAST) & (clk_cnt_nx == CLK_LAST));
  end

  // Register encoder state and the stream outputs.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cell_cnt_r <= 4'd0;
      clk_cnt_r  <= CLK_ZERO;
      shreg_r    <= 16'h0000;
      prev_r     <= 1'b0;
      mfm_r      <= 1'b0;
      strobe_r   <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_nx;
      cell_cnt_r <= cell_cnt_nx;
      clk_cnt_r  <= clk_cnt_nx;
      shreg_r    <= shreg_nx;
      prev_r     <= prev_nx;
      mfm_r      <= mfm_nx;
      strobe_r   <= strobe_nx;
      ready_r    <= ready_nx;
    end
  end

  // Sticky underrun flag; a new underrun outranks a same-cycle index clear.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      underrun_r <= 1'b0;
    end else if (set_underrun_s) begin
      underrun_r <= 1'b1;
    end else if (track_start_s) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign byte_if.byte_ready = ready_r;
  assign mfm_out            = mfm_r;
  assign cell_strobe        = strobe_r;
  assign track_start        = track_start_s;
  assign underrun           = underrun_r;

endmodule
